mod_addsub_scheduler: RTL and testbench

Two-requester round-robin scheduler in front of the shared modular adder/subtractor datapath. It accepts add/subtract commands from two clients and issues at most one per cycle to the datapath. It tracks each in-flight operation through the datapath's fixed pipeline latency and returns results in issue order through a credit-protected response FIFO. Results are never dropped.

---
 rtl/mod_addsub_scheduler.sv | 129 ++++++++++++
 tb/tb_mod_addsub_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_addsub_scheduler.sv
// Two-requester round-robin scheduler feeding a shared modular add/sub datapath.
// Commands are issued one per cycle, tracked through the datapath pipeline, and returned in order.
module mod_addsub_scheduler #(
  parameter int W       = 4,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         dp_valid,
  output logic         dp_op,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  input  logic [W-1:0] dp_result,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [W-1:0] resp_data,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + LATENCY + 2) + 1;

  // Handshake: a request transfers on the rising edge where valid & ready are both high.
  // ready is a function of valid; a requester must never derive valid from ready.

  logic          prio_q, prio_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0] infl_q, infl_d;
  logic          credit_ok, grant0, grant1, accept;
  logic          push, pop, cap_v, cap_id;

  logic          dp_op_q;
  logic [W-1:0]  dp_a_q, dp_b_q;
  logic [LATENCY:0] vld_q, id_q;

  logic [W:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;

  // fifo_cnt + inflight counts every accepted command not yet popped, so a slot is always reserved.
  assign credit_ok = (fifo_cnt_q + infl_q) < CW'(DEPTH);
  assign grant0    = rst_n & credit_ok & req0_valid & (~prio_q | ~req1_valid);
  assign grant1    = rst_n & credit_ok & req1_valid & (prio_q | ~req0_valid);
  assign accept    = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Stage 0 of the delay line is the issue register itself.
  assign cap_v  = vld_q[LATENCY];
  assign cap_id = id_q[LATENCY];
  assign push   = cap_v;
  assign pop    = (fifo_cnt_q != '0) & resp_ready;

  always_comb begin
    prio_d = prio_q;
    if (grant0)      prio_d = 1'b1;
    else if (grant1) prio_d = 1'b0;
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CW'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - CW'(1);
  end

  always_comb begin
    infl_d = infl_q;
    if (accept && !cap_v)      infl_d = infl_q + CW'(1);
    else if (!accept && cap_v) infl_d = infl_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      fifo_cnt_q <= '0;
      infl_q     <= '0;
      dp_op_q    <= 1'b0;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      vld_q      <= '0;
      id_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      prio_q     <= prio_d;
      fifo_cnt_q <= fifo_cnt_d;
      infl_q     <= infl_d;
      if (accept) begin
        dp_op_q <= grant1 ? req1_op : req0_op;
        dp_a_q  <= grant1 ? req1_a  : req0_a;
        dp_b_q  <= grant1 ? req1_b  : req0_b;
      end
      vld_q[0] <= accept;
      id_q[0]  <= grant1;
      for (int k = 1; k <= LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        id_q[k]  <= id_q[k-1];
      end
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cap_id, dp_result};
  end

  assign dp_valid   = vld_q[0];
  assign dp_op      = dp_op_q;
  assign dp_a       = dp_a_q;
  assign dp_b       = dp_b_q;
  assign resp_valid = (fifo_cnt_q != '0);
  // Head contents are masked while empty so the outputs read zero out of reset.
  assign resp_id    = resp_valid ? mem_q[rd_ptr_q][W]     : 1'b0;
  assign resp_data  = resp_valid ? mem_q[rd_ptr_q][W-1:0] : '0;
  assign busy       = (fifo_cnt_q != '0) | (infl_q != '0);

endmodule

// File: tb/tb_mod_addsub_scheduler.sv
// Bench for mod_addsub_scheduler: random and directed commands, reference model of
// round-robin grant, credit, and in-order results, with a decoupled response monitor.
module tb_mod_addsub_scheduler;
  localparam int W     = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req0_op = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0;
  logic         req1_valid = 1'b0, req1_op = 1'b0;
  logic [W-1:0] req1_a = '0, req1_b = '0;
  logic         req0_ready, req1_ready;
  logic         dp_valid, dp_op;
  logic [W-1:0] dp_a, dp_b, dp_result;
  logic         resp_valid, resp_id;
  logic         resp_ready = 1'b0;
  logic [W-1:0] resp_data;
  logic         busy;

  // clock / reset
  always #5 clk = ~clk;

  mod_addsub_scheduler #(.W(W), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .dp_valid(dp_valid), .dp_op(dp_op), .dp_a(dp_a), .dp_b(dp_b),
    .dp_result(dp_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .busy(busy)
  );

  // datapath stub: two-register chain computing the modular sum or difference
  logic [W-1:0] st1_q, st2_q;
  always @(posedge clk) begin
    st1_q <= dp_op ? (dp_a - dp_b) : (dp_a + dp_b);
    st2_q <= st1_q;
  end
  assign dp_result = st2_q;

  // scoreboard state: every accepted command not yet popped, in accept order
  logic [W:0] exp_q[$];
  int         due_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  bit         prio_m = 1'b0;
  bit         last_acc = 1'b0;
  bit         last_op;
  logic [W-1:0] last_a, last_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
    int r;
    r = op ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    r = r & ((1 << W) - 1);
    return r[W-1:0];
  endfunction

  // monitor: checks the FIFO head whenever the model says a result is visible
  initial begin
    forever begin
      bit due, pp;
      @(negedge clk);
      due = 1'b0;
      pp  = 1'b0;
      if (!rst_n) begin
        exp_q.delete();
        due_q.delete();
      end else begin
        if (exp_q.size() != 0) due = (due_q[0] <= cyc);
        chk("resp_valid", resp_valid, due);
        if (due) begin
          chk("resp_id", resp_id, exp_q[0][W]);
          chk("resp_data", resp_data, exp_q[0][W-1:0]);
          pp = resp_ready;
        end
      end
      @(posedge clk);
      #1;
      if (pp) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
  end

  // driver: one cycle of stimulus, grant prediction, and expected-result push
  task automatic step(input bit v0, input bit o0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input bit v1, input bit o1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                      input bit rr);
    bit e0, e1, room;
    int due;
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    resp_ready = rr;
    @(negedge clk);
    room = (exp_q.size() < DEPTH);
    e0 = room && v0 && (!prio_m || !v1);
    e1 = room && v1 && (prio_m || !v0);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("busy", busy, exp_q.size() != 0);
    chk("dp_valid", dp_valid, last_acc);
    if (last_acc) begin
      chk("dp_op", dp_op, last_op);
      chk("dp_a", dp_a, last_a);
      chk("dp_b", dp_b, last_b);
    end
    due = cyc + LAT + 2;
    @(posedge clk);
    #1;
    last_acc = e0 | e1;
    if (e0) begin
      exp_q.push_back({1'b0, ref_result(o0, a0, b0)});
      due_q.push_back(due);
      prio_m = 1'b1;
      last_op = o0; last_a = a0; last_b = b0;
    end else if (e1) begin
      exp_q.push_back({1'b1, ref_result(o1, a1, b1)});
      due_q.push_back(due);
      prio_m = 1'b0;
      last_op = o1; last_a = a1; last_b = b1;
    end
  endtask

  task automatic rstep(input bit v0, input bit v1, input bit rr);
    step(v0, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
         v1, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom), rr);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) rstep(1'b0, 1'b0, 1'b1);
    chk("drained", exp_q.size(), 0);
    rstep(1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      req0_valid = 1'($urandom_range(0, 1)); req0_op = 1'($urandom_range(0, 1));
      req0_a = W'($urandom); req0_b = W'($urandom);
      req1_valid = 1'($urandom_range(0, 1)); req1_op = 1'($urandom_range(0, 1));
      req1_a = W'($urandom); req1_b = W'($urandom);
      resp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_dp_valid", dp_valid, 0);
      chk("rst_dp_op", dp_op, 0);
      chk("rst_dp_a", dp_a, 0);
      chk("rst_dp_b", dp_b, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      @(posedge clk);
      #1;
    end
    prio_m   = 1'b0;
    last_acc = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset(3);

    // single add straight after reset release: 5 + 9 = 14 from requester 0
    step(1'b1, 1'b0, 4'd5, 4'd9, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    drain();

    // arbitration: 3 - 7 from requester 0 against 8 + 8 from requester 1
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 4'd3, 4'd7, 1'b1, 1'b0, 4'd8, 4'd8, 1'b1);
    drain();

    // backpressure, single pop, then one extra accept
    for (int i = 0; i < 7; i++) rstep(1'b1, 1'b0, 1'b0);
    rstep(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) rstep(1'b1, 1'b0, 1'b0);

    // full FIFO drained while new commands keep capturing
    for (int i = 0; i < 10; i++) rstep(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    drain();

    // reset with two commands in flight and one buffered
    for (int i = 0; i < 3; i++) rstep(1'b1, 1'b0, 1'b0);
    rstep(1'b0, 1'b0, 1'b0);
    do_reset(2);
    for (int i = 0; i < 4; i++) rstep(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd6, 4'd7, 1'b1, 1'b1, 4'd2, 4'd9, 1'b1);
    drain();

    // random traffic
    for (int i = 0; i < 300; i++)
      rstep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
